// File: rtl/apb_master_bridge.sv
// APB requester: takes one command at a time on a valid/ready port, runs SETUP/ACCESS
// against slave 1 or 2 (address MSB) and returns read data or a timeout error strobe.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    localparam int unsigned CntW           = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TimeoutLastInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CntW-1:0] TimeoutLast = TimeoutLastInt[CntW-1:0];

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sel2_q, sel2_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic              accept;
    logic              pready_sel;
    logic [DATA_W-1:0] prdata_sel;
    logic              timeout_hit;

    // Only the latched target's handshake is ever looked at.
    assign pready_sel  = sel2_q ? PREADY2 : PREADY1;
    assign prdata_sel  = sel2_q ? PRDATA2 : PRDATA1;
    assign accept      = (state_q == StIdle) && req_valid && req_ready_q;
    // Abort at the end of the TIMEOUT-th ACCESS cycle that still sees no PREADY.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel2_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel2_q      <= sel2_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready_sel || timeout_hit) begin
                    state_d = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel2_d      = sel2_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        psel1_d     = 1'b0;
        psel2_d     = 1'b0;
        penable_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    sel2_d      = req_addr[ADDR_W];
                    pwrite_d    = req_write;
                    paddr_d     = req_addr[ADDR_W-1:0];
                    pwdata_d    = req_wdata;
                    psel1_d     = !req_addr[ADDR_W];
                    psel2_d     = req_addr[ADDR_W];
                end
            end
            StSetup: begin
                psel1_d   = !sel2_q;
                psel2_d   = sel2_q;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pready_sel) begin
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
                end else if (timeout_hit) begin
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    psel1_d   = !sel2_q;
                    psel2_d   = sel2_q;
                    penable_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed requests push expected responses,
// a negedge monitor pops and compares them (data, error flag, arrival cycle).
module tb_apb_master_bridge;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW:0]   req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL1, PSEL2, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA1, PRDATA2;
    logic          PREADY1, PREADY2;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PSEL2     (PSEL2),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA1   (PRDATA1),
        .PRDATA2   (PRDATA2),
        .PREADY1   (PREADY1),
        .PREADY2   (PREADY2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int setups   = 0;
    int accepts  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Slave models: memories, programmable wait states, optional forced PREADY.
    logic [DW-1:0] mem1 [0:255];
    logic [DW-1:0] mem2 [0:255];
    bit mem_clr = 1'b1;
    bit force1 = 1'b0, force2 = 1'b0;
    int delay1 = 0, delay2 = 0, wait1 = 0, wait2 = 0;

    assign PREADY1 = force1 | (PSEL1 && PENABLE && (wait1 >= delay1));
    assign PREADY2 = force2 | (PSEL2 && PENABLE && (wait2 >= delay2));
    assign PRDATA1 = mem1[PADDR];
    assign PRDATA2 = mem2[PADDR];

    always @(posedge clk) begin
        wait1 <= (PSEL1 && PENABLE && !PREADY1) ? wait1 + 1 : 0;
        wait2 <= (PSEL2 && PENABLE && !PREADY2) ? wait2 + 1 : 0;
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'h00;
                mem2[i] <= 8'(i) ^ 8'h3C;
            end
        end else begin
            if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
            if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
        end
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [30:0] all_out;
    assign all_out = {req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2, PENABLE,
                      PWRITE, PADDR, PWDATA};

    always @(negedge clk) begin
        if (reset) begin
            if (PSEL1 || PSEL2) check("psel_onehot", PSEL1 & PSEL2, 1'b0);
            if ((PSEL1 || PSEL2) && !PENABLE) setups <= setups + 1;
            if (rsp_valid) begin
                check("rsp_expected", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", rsp_err, mon_e.err);
                    check("rsp_cycle", cyc, mon_e.due);
                end
            end else if (rsp_err || (rsp_rdata != '0)) begin
                check("rsp_idle_zero", {rsp_err, rsp_rdata}, '0);
            end
        end
    end

    // lat: cycles from the accept edge to the rsp_valid cycle (3 = zero wait).
    task automatic do_req(input bit wr, input logic [AW:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input bit exp_err, input int lat,
                          input bit hold, input bit push);
        int   acc;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        check("accept", acc >= 0, 1'b1);
        if (acc < 0) begin
            req_valid = 1'b0;
            return;
        end
        accepts++;
        if (push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.due   = acc + lat - 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check("setup_ctrl", {PSEL1, PSEL2, PENABLE, req_ready}, {!addr[AW], addr[AW], 2'b00});
        check("setup_bus", {PWRITE, PADDR, PWDATA}, {wr, addr[AW-1:0], wd});
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
        check("access_ctrl", {PSEL1, PSEL2, PENABLE, req_ready}, {!addr[AW], addr[AW], 2'b10});
        check("access_bus", {PWRITE, PADDR, PWDATA}, {wr, addr[AW-1:0], wd});
    endtask

    task automatic wait_rsp(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                check("rsp_bus_idle", {PSEL1, PSEL2, PENABLE, req_ready}, 4'b0001);
                req_valid = 1'b0;
            end
        end
        check("rsp_seen", seen, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, '0);
        reset   = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);
        check("idle_ready", req_ready, 1'b1);

        // Write slave 1 with PREADY1 tied high (also high in IDLE/SETUP, must be ignored).
        force1 = 1'b1;
        do_req(1'b1, 9'h005, 8'hA5, 8'h00, 1'b0, 3, 1'b0, 1'b1);
        wait_rsp(10);
        force1 = 1'b0;

        // Read back from slave 1.
        do_req(1'b0, 9'h005, 8'h00, 8'hA5, 1'b0, 3, 1'b0, 1'b1);
        wait_rsp(10);

        // Slave 2 read with three wait states: 0xFF ^ 0x3C = 0xC3.
        delay2 = 3;
        do_req(1'b0, 9'h1FF, 8'h00, 8'hC3, 1'b0, 6, 1'b0, 1'b1);
        wait_rsp(12);
        delay2 = 0;

        // Timeout on slave 1: abort after four ACCESS cycles, no write lands.
        delay1 = 1000;
        do_req(1'b1, 9'h033, 8'h77, 8'h00, 1'b1, 6, 1'b0, 1'b1);
        wait_rsp(12);
        check("abort_no_write", mem1[8'h33], 8'h00);

        // Reset during ACCESS drops the transfer silently.
        do_req(1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outputs", all_out, '0);
        reset  = 1'b1;
        delay1 = 0;
        repeat (4) @(negedge clk);
        do_req(1'b0, 9'h005, 8'h00, 8'hA5, 1'b0, 3, 1'b0, 1'b1);
        wait_rsp(10);

        // req_valid held through a slave-1 transfer while PREADY2 is forced high.
        delay1 = 2;
        force2 = 1'b1;
        do_req(1'b0, 9'h005, 8'h00, 8'hA5, 1'b0, 5, 1'b1, 1'b1);
        wait_rsp(12);
        force2 = 1'b0;
        delay1 = 0;

        // Slave 2 write then read back; slave 1 holds 0 at that address.
        do_req(1'b1, 9'h1AB, 8'h5A, 8'h00, 1'b0, 3, 1'b0, 1'b1);
        wait_rsp(10);
        do_req(1'b0, 9'h1AB, 8'h00, 8'h5A, 1'b0, 3, 1'b0, 1'b1);
        wait_rsp(10);

        repeat (4) @(negedge clk);
        check("setup_count", setups, accepts);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
